// File: rtl/mips_sc_cpu.sv
// Single-cycle MIPS-subset CPU: add/sub/and/or/slt, addi, lw, sw, beq.
// The instruction memory, register file and data memory are sub-instances that the bench preloads and inspects.

module mips_im (
  input  logic        CLK,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] InstrMemory [0:31];

  // The write port is tied off at the top; program images are loaded hierarchically.
  always_ff @(posedge CLK) begin
    if (we) InstrMemory[waddr] <= wdata;
  end

  assign instr = InstrMemory[addr];
endmodule

module mips_regfile (
  input  logic        CLK,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] Register [0:31];

  always_ff @(posedge CLK) begin
    if (we) Register[wa] <= wd;
  end

  assign rd1 = Register[ra1];
  assign rd2 = Register[ra2];
endmodule

module mips_dm (
  input  logic        CLK,
  input  logic [4:0]  addr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] wdata
);
  logic [31:0] DataMemory [0:31];

  always_ff @(posedge CLK) begin
    if (we) DataMemory[addr] <= wdata;
  end

  assign rdata = DataMemory[addr];
endmodule

module mips_sc_cpu (
  input  logic CLK,
  input  logic RST,
  input  logic START
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [31:0] pc_reg, pc_next, pc_plus4;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_y;
  logic [31:0] dm_rdata;
  logic        reg_we, dm_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        run;
  logic        unused_shamt;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_ext  = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4 = pc_reg + 32'd4;
  assign unused_shamt = ^instr[10:6];

  // Writes only happen on a retiring edge; reset always wins over START.
  assign run = START & ~RST;

  mips_im i_IM (
    .CLK   (CLK),
    .we    (1'b0),
    .waddr (5'd0),
    .wdata (32'd0),
    .addr  (pc_reg[6:2]),
    .instr (instr)
  );

  mips_regfile i_Reg (
    .CLK (CLK),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (reg_we & run),
    .wa  (reg_wa),
    .wd  (reg_wd)
  );

  mips_dm i_DM (
    .CLK   (CLK),
    .addr  (alu_y[6:2]),
    .rdata (dm_rdata),
    .we    (dm_we & run),
    .wdata (rt_val)
  );

  // ALU: R-type ops by funct, otherwise the rs+imm address/immediate sum.
  always_comb begin
    alu_y = rs_val + imm_ext;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_y = rs_val + rt_val;
        FN_SUB:  alu_y = rs_val - rt_val;
        FN_AND:  alu_y = rs_val & rt_val;
        FN_OR:   alu_y = rs_val | rt_val;
        FN_SLT:  alu_y = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
        default: alu_y = 32'd0;
      endcase
    end
  end

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rt;
    reg_wd  = alu_y;
    dm_we   = 1'b0;
    pc_next = pc_plus4;
    case (op)
      OP_RTYPE: begin
        reg_wa = rd;
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: reg_we = 1'b1;
          default:                               reg_we = 1'b0;
        endcase
      end
      OP_ADDI: reg_we = 1'b1;
      OP_LW: begin
        reg_we = 1'b1;
        reg_wd = dm_rdata;
      end
      OP_SW:  dm_we = 1'b1;
      OP_BEQ: begin
        if (rs_val == rt_val) pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) pc_reg <= 32'd0;
    else if (START) pc_reg <= pc_next;
  end
endmodule

// File: tb/tb_mips_sc_cpu.sv
// Bench for mips_sc_cpu: directed program scenarios plus random programs,
// every cycle compared against an instruction-level model of PC, registers and data memory.

module tb_mips_sc_cpu;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;

  int total = 0;
  int passed = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_dm  [32];
  logic [31:0] m_im  [32];
  logic [31:0] m_pc;

  mips_sc_cpu dut (.CLK(CLK), .RST(RST), .START(START));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Instruction-level model: one architectural step from the rules, not from the datapath.
  task automatic model_step(input logic s, input logic r);
    logic [31:0] ins, a, b, addr;
    int op, rs, rt, rd, fn, simm;
    if (r) begin
      m_pc = 0;
      return;
    end
    if (!s) return;
    ins  = m_im[(m_pc / 4) % 32];
    op   = int'(ins >> 26);
    rs   = int'((ins >> 21) % 32);
    rt   = int'((ins >> 16) % 32);
    rd   = int'((ins >> 11) % 32);
    fn   = int'(ins % 64);
    simm = int'($signed(ins[15:0]));
    a = m_reg[rs];
    b = m_reg[rt];
    addr = a + simm;
    m_pc = m_pc + 4;
    case (op)
      0: case (fn)
           32: m_reg[rd] = a + b;
           34: m_reg[rd] = a - b;
           36: m_reg[rd] = a & b;
           37: m_reg[rd] = a | b;
           42: m_reg[rd] = (int'(a) < int'(b)) ? 1 : 0;
           default: ;
         endcase
      8:  m_reg[rt] = addr;
      35: m_reg[rt] = m_dm[(addr / 4) % 32];
      43: m_dm[(addr / 4) % 32] = b;
      4:  if (a == b) m_pc = m_pc + simm * 4;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("pc", 32'(dut.pc_reg[6:2]), (m_pc / 4) % 32);
    for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut.i_Reg.Register[i], m_reg[i]);
    for (int i = 0; i < 32; i++) chk($sformatf("dm%0d", i), dut.i_DM.DataMemory[i], m_dm[i]);
  endtask

  task automatic cycle(input logic s, input logic r);
    @(negedge CLK);
    START = s;
    RST   = r;
    model_step(s, r);
    @(posedge CLK);
    #1;
    $display("cycle start=%0b rst=%0b pc_word=%0d", s, r, dut.pc_reg[6:2]);
    compare_all();
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    m_im[idx] = w;
    dut.i_IM.InstrMemory[idx] <= w;
  endtask

  // Preload with RST held so the CPU writes nothing meanwhile, then one checked reset cycle.
  task automatic preload(input bit rnd);
    @(negedge CLK);
    RST = 1'b1;
    START = 1'b0;
    for (int k = 0; k < 32; k++) begin
      m_reg[k] = rnd ? $urandom : ((k < 8) ? k + 1 : 0);
      m_dm[k]  = rnd ? $urandom : ((k < 8) ? k + 1 : 0);
      m_im[k]  = 0;
      dut.i_Reg.Register[k]    <= m_reg[k];
      dut.i_DM.DataMemory[k]   <= m_dm[k];
      dut.i_IM.InstrMemory[k]  <= 32'd0;
    end
  endtask

  task automatic load_rseq();
    put(0, enc_r(1, 2, 3, 6'b100000));
    put(1, enc_r(5, 1, 4, 6'b100010));
    put(2, enc_r(6, 7, 5, 6'b100100));
    put(3, enc_r(1, 2, 6, 6'b101010));
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0: return enc_r(rs, rt, rd, 6'b100000);
      1: return enc_r(rs, rt, rd, 6'b100010);
      2: return enc_r(rs, rt, rd, 6'b100100);
      3: return enc_r(rs, rt, rd, 6'b100101);
      4: return enc_r(rs, rt, rd, 6'b101010);
      5: return enc_i(6'b001000, rs, rt, $urandom_range(0, 65535));
      6: return enc_i(6'b100011, rs, rt, $urandom_range(0, 65535));
      7: return enc_i(6'b101011, rs, rt, $urandom_range(0, 65535));
      8: return enc_i(6'b000100, rs, rt, int'($urandom_range(0, 6)) - 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // R-type sequence, with explicit results per retired instruction.
    preload(0);
    load_rseq();
    cycle(0, 1);
    chk("reset_pc", 32'(dut.pc_reg[6:2]), 0);
    cycle(1, 0); chk("add_r3", dut.i_Reg.Register[3], 5);
    cycle(1, 0); chk("sub_r4", dut.i_Reg.Register[4], 4);
    cycle(1, 0); chk("and_r5", dut.i_Reg.Register[5], 0);
    cycle(1, 0); chk("slt_r6", dut.i_Reg.Register[6], 1);

    // slt both ways, including a negative operand.
    preload(0);
    put(0, enc_r(2, 1, 7, 6'b101010));
    put(1, enc_r(1, 2, 1, 6'b100010));
    put(2, enc_r(1, 0, 7, 6'b101010));
    cycle(0, 1);
    cycle(1, 0); chk("slt_false", dut.i_Reg.Register[7], 0);
    cycle(1, 0); chk("sub_neg", dut.i_Reg.Register[1], 32'hFFFF_FFFF);
    cycle(1, 0); chk("slt_neg", dut.i_Reg.Register[7], 1);

    // Load and store.
    preload(0);
    put(0, enc_i(6'b100011, 3, 2, 0));
    put(1, enc_i(6'b101011, 3, 1, 4));
    cycle(0, 1);
    cycle(1, 0); chk("lw_r2", dut.i_Reg.Register[2], 2);
    cycle(1, 0); chk("sw_dm2", dut.i_DM.DataMemory[2], 2);

    // Branch taken skips word 1; branch not taken falls through.
    preload(0);
    put(0, enc_i(6'b000100, 1, 1, 1));
    put(1, enc_i(6'b001000, 0, 9, 77));
    put(2, enc_i(6'b001000, 0, 10, 5));
    put(3, enc_i(6'b000100, 1, 2, 1));
    put(4, enc_i(6'b001000, 0, 11, 6));
    cycle(0, 1);
    cycle(1, 0); chk("beq_taken_pc", 32'(dut.pc_reg[6:2]), 2);
    cycle(1, 0); chk("skip_r9", dut.i_Reg.Register[9], 0);
    chk("addi_r10", dut.i_Reg.Register[10], 6);
    cycle(1, 0); chk("beq_not_taken_pc", 32'(dut.pc_reg[6:2]), 4);
    cycle(1, 0); chk("addi_r11", dut.i_Reg.Register[11], 7);

    // START held low: nothing changes until the first edge with START=1.
    preload(0);
    load_rseq();
    cycle(0, 1);
    cycle(0, 0); chk("hold_r3", dut.i_Reg.Register[3], 4);
    cycle(0, 0); chk("hold_pc", 32'(dut.pc_reg[6:2]), 0);
    cycle(1, 0); chk("start_r3", dut.i_Reg.Register[3], 5);

    // Mid-program reset discards the current instruction and keeps registers.
    preload(0);
    load_rseq();
    cycle(0, 1);
    cycle(1, 0);
    cycle(1, 0);
    cycle(1, 1); chk("rst_pc", 32'(dut.pc_reg[6:2]), 0);
    chk("rst_nowrite_r5", dut.i_Reg.Register[5], 6);
    chk("rst_keep_r4", dut.i_Reg.Register[4], 4);
    cycle(1, 0); chk("rerun_pc", 32'(dut.pc_reg[6:2]), 1);

    // Random programs with occasional stalls and resets.
    for (int p = 0; p < 4; p++) begin
      preload(1);
      for (int k = 0; k < 32; k++) put(k, rand_instr());
      cycle(0, 1);
      for (int c = 0; c < 150; c++)
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
